// File: rtl/wb_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_initiator_pkg
// Description : Shared types and constants for the Wishbone classic initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_initiator_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [WB_DAT_W-1:0] WB_ERR_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbi_state_e;

endpackage : wb_initiator_pkg
`default_nettype wire

// File: rtl/wbi_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : wbi_timeout_ctr
// Description : Counts stb cycles without ack; flags the last permitted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wbi_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TO_W-1:0] c_last = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_count;

    // Holds at the terminal value so an enable past expiry cannot wrap.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == c_last);

endmodule : wbi_timeout_ctr
`default_nettype wire

// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : wb_initiator
// Description : Single-outstanding Wishbone B4 classic initiator with
//               valid/ready command and response streams and a bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,

    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    input  logic                wbm_ack_i
);

    wbi_state_e          r_state;
    wbi_state_e          w_state_nxt;

    logic                r_cyc,       w_cyc_nxt;
    logic                r_we,        w_we_nxt;
    logic [WB_ADR_W-1:0] r_adr,       w_adr_nxt;
    logic [WB_DAT_W-1:0] r_dat,       w_dat_nxt;
    logic [WB_SEL_W-1:0] r_sel,       w_sel_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [WB_DAT_W-1:0] r_rsp_dat,   w_rsp_dat_nxt;
    logic                r_rsp_err,   w_rsp_err_nxt;

    logic                w_accept;
    logic                w_to_enable;
    logic                w_expired;

    assign cmd_ready   = (r_state == IDLE) && !wb_rst_i;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_to_enable = (r_state == BUS) && !wbm_ack_i;

    wbi_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_clear   (w_accept),
        .i_enable  (w_to_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cyc_nxt       = r_cyc;
        w_we_nxt        = r_we;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;
        w_sel_nxt       = r_sel;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_we_nxt    = cmd_we;
                    w_adr_nxt   = cmd_adr;
                    w_dat_nxt   = cmd_dat;
                    w_sel_nxt   = cmd_sel;
                    w_cyc_nxt   = 1'b1;
                    w_state_nxt = BUS;
                end
            end
            BUS: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (wbm_ack_i) begin
                    w_rsp_dat_nxt   = r_we ? WB_ERR_DATA : wbm_dat_i;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_cyc_nxt       = 1'b0;
                    w_state_nxt     = RESP;
                end else if (w_expired) begin
                    w_rsp_dat_nxt   = WB_ERR_DATA;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_cyc_nxt       = 1'b0;
                    w_state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_cyc_nxt       = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_cyc       <= w_cyc_nxt;
            r_we        <= w_we_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_sel       <= w_sel_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    // cyc and stb share one register so they can never diverge.
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;

    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;

endmodule : wb_initiator
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_initiator
// Description : Directed self-checking bench for wb_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_valid4;
    logic        cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_ready;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_ack4;

    logic        cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o;
    logic [3:0]  sel;

    logic        cmd_ready4, rsp_valid4, rsp_err4;
    logic [31:0] rsp_dat4;
    logic        cyc4, stb4, we4;
    logic [31:0] adr4, dat_o4;
    logic [3:0]  sel4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT_CYCLES(8)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
        .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    wb_initiator #(.TIMEOUT_CYCLES(4)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat4), .rsp_err(rsp_err4),
        .wbm_cyc_o(cyc4), .wbm_stb_o(stb4), .wbm_we_o(we4), .wbm_adr_o(adr4),
        .wbm_dat_o(dat_o4), .wbm_sel_o(sel4), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_after_consume", {31'b0, rsp_valid}, 32'd0);
        check("cmd_ready_after_consume", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int stb_cnt;
        rst = 1'b1; cmd_valid = 1'b0; cmd_valid4 = 1'b0; cmd_we = 1'b0;
        cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; rsp_ready = 1'b0;
        wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_ack4 = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        check("rst_rsp_dat",   rsp_dat,            32'd0);
        check("rst_cyc_stb",   {30'b0, cyc, stb},  32'd0);
        check("rst_adr",       adr,                32'd0);
        check("rst_dat_sel_we", {27'b0, sel, we},  32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Read, zero-wait slave
        send(1'b0, 32'h3000_0004, 32'h1111_2222, 4'hF);
        check("rd_cyc_stb",   {30'b0, cyc, stb}, 32'd3);
        check("rd_adr",       adr,               32'h3000_0004);
        check("rd_sel_we",    {27'b0, sel, we},  {27'b0, 4'hF, 1'b0});
        check("rd_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("rd_rsp_early", {31'b0, rsp_valid}, 32'd0);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        check("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rd_rsp_dat",   rsp_dat,            32'hCAFE_F00D);
        check("rd_rsp_err",   {31'b0, rsp_err},   32'd0);
        check("rd_cyc_drop",  {30'b0, cyc, stb},  32'd0);
        consume();

        // Write, 3 wait states, then response backpressure
        send(1'b1, 32'h3000_0008, 32'hA5A5_0001, 4'b0011);
        for (int i = 1; i <= 4; i++) begin
            check("wr_cyc_stb", {30'b0, cyc, stb}, 32'd3);
            check("wr_adr",     adr,   32'h3000_0008);
            check("wr_dat",     dat_o, 32'hA5A5_0001);
            check("wr_sel_we",  {27'b0, sel, we}, {27'b0, 4'b0011, 1'b1});
            check("wr_no_rsp",  {31'b0, rsp_valid}, 32'd0);
            if (i == 4) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h1234_5678;
            end
            tick();
        end
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        check("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("wr_rsp_dat",   rsp_dat,            32'd0);
        check("wr_rsp_err",   {31'b0, rsp_err},   32'd0);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_00FC;
        for (int i = 0; i < 10; i++) begin
            check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_rsp_dat",   rsp_dat,            32'd0);
            check("bp_no_bus",    {30'b0, cyc, stb},  32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        consume();

        // Timeout, TIMEOUT_CYCLES = 8, slave silent
        send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        wbm_dat_i = 32'hFFFF_FFFF;
        stb_cnt = 0;
        for (int i = 0; i < 20 && stb; i++) begin
            stb_cnt++;
            tick();
        end
        wbm_dat_i = 32'h0;
        check("to_stb_cycles", stb_cnt,            32'd8);
        check("to_rsp_valid",  {31'b0, rsp_valid}, 32'd1);
        check("to_rsp_err",    {31'b0, rsp_err},   32'd1);
        check("to_rsp_dat",    rsp_dat,            32'd0);
        consume();

        // Next command after a timeout
        send(1'b0, 32'h3000_0020, 32'h0, 4'h1);
        check("post_to_adr", adr, 32'h3000_0020);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_BEEF;
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        check("post_to_rsp_dat", rsp_dat,          32'h0BAD_BEEF);
        check("post_to_rsp_err", {31'b0, rsp_err}, 32'd0);
        consume();

        // Stray ack in IDLE
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h5555_AAAA;
        tick();
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        check("stray_cyc",       {30'b0, cyc, stb},  32'd0);
        check("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("stray_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Reset during BUS cycle 2
        send(1'b1, 32'h3000_0030, 32'h7777_7777, 4'hF);
        tick();
        check("mid_rst_cycle2", {30'b0, cyc, stb}, 32'd3);
        rst = 1'b1;
        tick();
        check("mid_rst_cyc_low", {30'b0, cyc, stb}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mid_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
            tick();
        end
        rsp_ready = 1'b0;

        // Ack on the expiring cycle, TIMEOUT_CYCLES = 4
        cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
        cmd_valid4 = 1'b1;
        tick();
        cmd_valid4 = 1'b0;
        tick();
        tick();
        tick();
        check("race_stb_cycle4", {30'b0, cyc4, stb4}, 32'd3);
        wbm_ack4 = 1'b1; wbm_dat_i = 32'hFACE_0042;
        tick();
        wbm_ack4 = 1'b0; wbm_dat_i = 32'h0;
        check("race_rsp_valid", {31'b0, rsp_valid4}, 32'd1);
        check("race_rsp_err",   {31'b0, rsp_err4},   32'd0);
        check("race_rsp_dat",   rsp_dat4,            32'hFACE_0042);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("race_done", {31'b0, rsp_valid4}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wb_initiator
`default_nettype wire
